// File: rtl/track_map_arbiter.sv
// track_map_arbiter
// Arbitrates the single-port track-map BRAM between the pixel renderer and the
// two kart-physics surface lookups (player = index 0, opponent = index 1).
//
// Handshake: a physics requester raises phys_req_in[i] with its address on
// phys_addr_in and holds both stable until it sees phys_gnt_out[i]. The grant
// is registered, so it shows in the cycle after the request was sampled. The
// request level seen during that grant cycle belongs to the transaction just
// granted and is ignored. From the following cycle the requester may drop req
// or present a new address. Render reads need no handshake: every cycle with
// render_req_in high is served. Each read returns exactly one valid pulse,
// RD_LATENCY+2 cycles after its request cycle.
module track_map_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 4,
  parameter int RD_LATENCY   = 2,
  parameter int STARVE_LIMIT = 1024
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  render_req_in,
  input  logic [ADDR_W-1:0]     render_addr_in,
  output logic [DATA_W-1:0]     render_data_out,
  output logic                  render_valid_out,
  input  logic [1:0]            phys_req_in,
  input  logic [2*ADDR_W-1:0]   phys_addr_in,
  output logic [1:0]            phys_gnt_out,
  output logic [DATA_W-1:0]     phys_data_out,
  output logic [1:0]            phys_valid_out,
  output logic [ADDR_W-1:0]     bram_addr_out,
  input  logic [DATA_W-1:0]     bram_data_in,
  output logic                  starve_out
);

  localparam int TAG_D = RD_LATENCY + 1;
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    SRC_RENDER = 2'd0,
    SRC_PLAYER = 2'd1,
    SRC_OPP    = 2'd2
  } src_e;

  // Round-robin pointer: 0 prefers player, 1 prefers opponent.
  logic              ptr;
  logic              ptr_next;
  logic              pick;
  logic [1:0]        req_eff;
  logic              slot_valid;
  src_e              slot_src;
  logic [ADDR_W-1:0] slot_addr;
  logic [1:0]        gnt_next;

  // Tag pipeline that travels alongside each BRAM read.
  logic [TAG_D-1:0]  tag_v;
  src_e              tag_src [TAG_D];

  // Per-requester wait counters.
  logic [CNT_W-1:0]  wait_cnt [2];
  logic [CNT_W-1:0]  wait_nxt [2];
  logic              starve_hit;

  // Slot selection: render first, then round-robin among eligible physics requests.
  always_comb begin
    req_eff    = phys_req_in & ~phys_gnt_out;
    slot_valid = 1'b0;
    slot_src   = SRC_RENDER;
    slot_addr  = bram_addr_out;
    gnt_next   = 2'b00;
    ptr_next   = ptr;
    pick       = 1'b0;
    if (render_req_in) begin
      slot_valid = 1'b1;
      slot_addr  = render_addr_in;
    end else if (|req_eff) begin
      if (req_eff == 2'b11) pick = ptr;
      else                  pick = req_eff[1];
      slot_valid = 1'b1;
      gnt_next   = pick ? 2'b10 : 2'b01;
      slot_src   = pick ? SRC_OPP : SRC_PLAYER;
      slot_addr  = pick ? phys_addr_in[2*ADDR_W-1:ADDR_W] : phys_addr_in[ADDR_W-1:0];
      ptr_next   = ~pick;
    end
  end

  // Wait-counter update: clear on grant, saturating count while waiting.
  always_comb begin
    starve_hit = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wait_nxt[i] = wait_cnt[i];
      if (gnt_next[i]) begin
        wait_nxt[i] = '0;
      end else if (req_eff[i] && (wait_cnt[i] != CNT_MAX)) begin
        wait_nxt[i] = wait_cnt[i] + 1'b1;
      end
      if (wait_nxt[i] == CNT_MAX) starve_hit = 1'b1;
    end
  end

  // Decision registers: BRAM address, grant pulse, pointer, starvation state.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      bram_addr_out <= '0;
      phys_gnt_out  <= 2'b00;
      ptr           <= 1'b0;
      starve_out    <= 1'b0;
      wait_cnt[0]   <= '0;
      wait_cnt[1]   <= '0;
    end else begin
      if (slot_valid) bram_addr_out <= slot_addr;
      phys_gnt_out <= gnt_next;
      ptr          <= ptr_next;
      wait_cnt[0]  <= wait_nxt[0];
      wait_cnt[1]  <= wait_nxt[1];
      if (starve_hit) starve_out <= 1'b1;
    end
  end

  // Tag shift register: stage 0 aligns with bram_addr_out, last stage with bram_data_in.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      tag_v <= '0;
      for (int i = 0; i < TAG_D; i++) tag_src[i] <= SRC_RENDER;
    end else begin
      tag_v[0]   <= slot_valid;
      tag_src[0] <= slot_src;
      for (int i = 1; i < TAG_D; i++) begin
        tag_v[i]   <= tag_v[i-1];
        tag_src[i] <= tag_src[i-1];
      end
    end
  end

  // Return stage: steer BRAM data to its owner with a single-cycle valid; data holds otherwise.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      render_data_out  <= '0;
      render_valid_out <= 1'b0;
      phys_data_out    <= '0;
      phys_valid_out   <= 2'b00;
    end else begin
      render_valid_out <= 1'b0;
      phys_valid_out   <= 2'b00;
      if (tag_v[TAG_D-1]) begin
        if (tag_src[TAG_D-1] == SRC_RENDER) begin
          render_valid_out <= 1'b1;
          render_data_out  <= bram_data_in;
        end else begin
          phys_valid_out <= (tag_src[TAG_D-1] == SRC_OPP) ? 2'b10 : 2'b01;
          phys_data_out  <= bram_data_in;
        end
      end
    end
  end

endmodule
